serial_slice_adder_ctrl: RTL and testbench
==========================================

// Module: serial_slice_adder_ctrl
//
// PURPOSE
// Multi-cycle controller that adds two WIDTH-bit operands by sequencing one
// SLICE-bit ripple-carry slice (a chain of one-bit full adder cells) over
// WIDTH/SLICE beats, carrying between beats in a register. It trades latency
// for area and is the sequencer in front of the slice adder. It uses a
// valid/ready handshake on both the operand and result sides.
//
// PARAMETERS
// WIDTH   12  operand/sum width in bits; must be an integer multiple of SLICE
// SLICE   3   bits added per beat (slice adder width)
// NBEATS  WIDTH/SLICE (localparam)  beats per operation; counter width is clog2(NBEATS)+1
//
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous active-low reset
// in_valid   in   1      operands a, b, c_in are valid
// in_ready   out  1      controller can accept operands (IDLE only)
// a          in   WIDTH  first operand, sampled only on accept
// b          in   WIDTH  second operand, sampled only on accept
// c_in       in   1      carry in, sampled only on accept
// out_valid  out  1      sum/c_out hold the completed result
// out_ready  in   1      consumer takes the result
// sum        out  WIDTH  result {a+b+c_in}[WIDTH-1:0]
// c_out      out  1      result bit WIDTH (final carry)
// busy       out  1      high in RUN or DONE
//
// BEHAVIOUR
// - One clock domain. rst_n low forces, asynchronously: state=IDLE, sum=0,
//   c_out=0, out_valid=0, busy=0, beat counter=0, operand shift regs=0,
//   carry reg=0. in_ready=1 follows from state IDLE.
// - FSM IDLE -> RUN -> DONE -> IDLE. The state alone decodes in_ready=(IDLE),
//   out_valid=(DONE) and busy=(RUN|DONE). All of these are registered-state
//   decodes with no input-to-output combinational path.
// - IDLE: on in_valid&in_ready, load a_sh<=a, b_sh<=b, carry<=c_in, cnt<=0,
//   and go to RUN. Without in_valid, stay in IDLE.
// - RUN, each clock: the slice adds a_sh[SLICE-1:0]+b_sh[SLICE-1:0]+carry.
//   sum<={slice_sum, sum[WIDTH-1:SLICE]} (the sum fills from the MSB end).
//   carry<=slice_cout. a_sh and b_sh shift right by SLICE, zero-filled.
//   cnt<=cnt+1. On the beat where cnt==NBEATS-1, go to DONE and set c_out<=slice_cout.
// - Latency: out_valid rises NBEATS clocks after the accept edge (4 for defaults).
// - DONE: sum and c_out are held stable. On out_ready, go to IDLE.
// - Minimum period between successive accepts is NBEATS+2 clocks.
// - in_valid is ignored outside IDLE, and a/b/c_in may change freely then.
//   out_ready is ignored outside DONE.
// - Overflow wraps modulo 2^WIDTH in sum, and bit WIDTH appears only on c_out.
// - Reset mid-RUN/DONE aborts the operation. No out_valid is produced for it,
//   and after release the controller is in IDLE, ready for a fresh operation.
// - sum/c_out change during RUN and are meaningful only while out_valid=1.
// - WIDTH==SLICE is legal: one RUN beat, latency 1.
//
// TESTING
// 1 Defaults: a=0xFFF, b=0x001, c_in=0 -> out_valid 4 clks after accept, sum=0x000, c_out=1.
// 2 a=0x5A5, b=0x3C3, c_in=1 -> sum=0x969, c_out=0. in_ready=0 and busy=1 from accept to handshake.
// 3 Backpressure: hold out_ready=0 for 10 clks in DONE with in_valid=1 and new operands
//   -> sum/c_out/out_valid stable, nothing accepted, result unchanged on release.
// 4 Assert rst_n low after 2 RUN beats -> all outputs at reset values immediately. After release,
//   a=0x001, b=0x002, c_in=0 -> sum=0x003, c_out=0.
// 5 in_valid and out_ready held high, two ops -> second accept exactly 2 clks after the first out_valid
//   rise (6-clk period). Both results correct.
// 6 WIDTH=3, SLICE=3: a=7, b=7, c_in=1 -> sum=7, c_out=1 after 1 clk. Plus 1000 random ops at
//   defaults checked against {c_out,sum}==a+b+c_in.

Source files
------------

// File: rtl/serial_slice_adder_ctrl.sv
// Purpose : serial adder; one SLICE-bit ripple slice sequenced over WIDTH/SLICE beats.
// Latency : out_valid rises WIDTH/SLICE clocks after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready low from accept to result handshake.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, c_in sampled on accept)
//   out_valid / out_ready result handshake (sum, c_out valid while out_valid)
//   busy                  operation in flight (RUN or DONE)
//
// WIDTH must be an integer multiple of SLICE; WIDTH == SLICE gives a single beat.

// Purpose : one-bit full adder cell.
// Latency : combinational.
// Backpressure: none.
module ssa_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// Purpose : SLICE-bit ripple-carry adder built from full adder cells.
// Latency : combinational.
// Backpressure: none.
module ssa_ripple_slice #(
   parameter int SLICE = 3
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co
);
   logic [SLICE:0] carry;

   assign carry[0] = ci;

   for (genvar i = 0; i < SLICE; i++) begin : g_cell
      ssa_full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry[i]),
         .s  (s[i]),
         .co (carry[i+1])
      );
   end

   assign co = carry[SLICE];
endmodule

// Purpose : sequencer driving the slice adder over WIDTH/SLICE beats with valid/ready on both sides.
// Latency : NBEATS clocks from accept edge to out_valid; NBEATS+2 clocks minimum between accepts.
// Backpressure: holds sum/c_out in DONE until out_ready; in_ready only in IDLE.
module serial_slice_adder_ctrl #(
   parameter int WIDTH = 12,
   parameter int SLICE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             busy
);
   localparam int NBEATS = WIDTH / SLICE;
   localparam int CNT_W  = $clog2(NBEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             load_op;
   logic             run_beat;
   logic             last_beat;

   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;

   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;

   // ------------------------------------------------------------------
   // Slice adder: always looks at the low SLICE bits of the shift regs.
   // ------------------------------------------------------------------
   ssa_ripple_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a  (a_sh[SLICE-1:0]),
      .b  (b_sh[SLICE-1:0]),
      .ci (carry),
      .s  (slice_sum),
      .co (slice_cout)
   );

   // Shift paths. A single-beat configuration has no upper bits to shift
   // down, so it is elaborated separately to keep every slice in range.
   if (WIDTH == SLICE) begin : g_one_beat
      assign sum_next = slice_sum;
      assign a_next   = '0;
      assign b_next   = '0;
   end else begin : g_multi_beat
      // Each beat's slice result enters at the MSB end; after NBEATS beats
      // the first slice has walked down to bit 0.
      assign sum_next = {slice_sum, sum[WIDTH-1:SLICE]};
      assign a_next   = {{SLICE{1'b0}}, a_sh[WIDTH-1:SLICE]};
      assign b_next   = {{SLICE{1'b0}}, b_sh[WIDTH-1:SLICE]};
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state and state decodes. Handshake outputs depend on state only,
   // so there is no combinational path from in_valid/out_ready to them.
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      load_op   = 1'b0;
      run_beat  = 1'b0;
      last_beat = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_op = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy     = 1'b1;
            run_beat = 1'b1;
            if (cnt == LAST_BEAT) begin
               last_beat = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         c_out <= 1'b0;
      end else if (load_op) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= c_in;
         cnt   <= '0;
      end else if (run_beat) begin
         a_sh  <= a_next;
         b_sh  <= b_next;
         carry <= slice_cout;
         cnt   <= cnt + CNT_W'(1);
         sum   <= sum_next;
         if (last_beat) begin
            c_out <= slice_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_slice_adder_ctrl.sv
// Purpose : self-checking bench for serial_slice_adder_ctrl (default and single-beat builds).
// Latency : n/a.
// Backpressure: exercised via out_ready stalls and random out_ready.
module tb_serial_slice_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, out_ready, c_in;
   logic [11:0] a, b;
   logic        in_ready, out_valid, c_out, busy;
   logic [11:0] sum;

   logic        s_in_valid, s_out_ready, s_c_in;
   logic [2:0]  s_a, s_b, s_sum;
   logic        s_in_ready, s_out_valid, s_c_out, s_busy;

   int          tests = 0;
   int          fails = 0;
   int          n_acc = 0;
   logic [12:0] exp_q[$];
   logic [12:0] sb_exp;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic        ci;
      logic [11:0] sum;
      logic        co;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   serial_slice_adder_ctrl #(.WIDTH(12), .SLICE(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .busy      (busy)
   );

   serial_slice_adder_ctrl #(.WIDTH(3), .SLICE(3)) dut_small (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .a         (s_a),
      .b         (s_b),
      .c_in      (s_c_in),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .sum       (s_sum),
      .c_out     (s_c_out),
      .busy      (s_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push the arithmetic model on accept, compare on result handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + {12'd0, c_in});
            n_acc++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
               sb_exp = exp_q.pop_front();
               chk("sb_result", {19'd0, c_out, sum}, {19'd0, sb_exp});
            end
         end
      end
   end

   // Runs one operation on the default DUT from an idle start; called at posedge+1.
   task automatic run_op(input logic [11:0] ai, input logic [11:0] bi, input logic ci,
                         output int lat, output logic [11:0] rs, output logic rc,
                         output logic hold_ok);
      int k;
      a = ai; b = bi; c_in = ci; in_valid = 1'b1; out_ready = 1'b0;
      hold_ok = 1'b1; lat = 0; rs = '0; rc = 1'b0;
      k = 0;
      while (!in_ready && k < 50) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         lat = -1;
         return;
      end
      tick();
      in_valid = 1'b0;
      a = 12'($urandom);
      b = 12'($urandom);
      do begin
         if (in_ready || !busy) hold_ok = 1'b0;
         tick();
         lat++;
      end while (!out_valid && lat < 50);
      if (in_ready || !busy) hold_ok = 1'b0;
      rs = sum;
      rc = c_out;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [11:0] rs;
      logic        rc;
      logic        hold_ok;
      logic        stable;
      logic [11:0] s0;
      logic        c0;
      int          n0, k, cyc;
      int          acc1, acc2, rise1;

      vecs[0] = '{a:12'hFFF, b:12'h001, ci:1'b0, sum:12'h000, co:1'b1};
      vecs[1] = '{a:12'h5A5, b:12'h3C3, ci:1'b1, sum:12'h969, co:1'b0};
      vecs[2] = '{a:12'h001, b:12'h002, ci:1'b0, sum:12'h003, co:1'b0};
      vecs[3] = '{a:12'h000, b:12'h000, ci:1'b0, sum:12'h000, co:1'b0};
      vecs[4] = '{a:12'hFFF, b:12'hFFF, ci:1'b1, sum:12'hFFF, co:1'b1};
      vecs[5] = '{a:12'h800, b:12'h800, ci:1'b0, sum:12'h000, co:1'b1};
      vecs[6] = '{a:12'h123, b:12'h456, ci:1'b0, sum:12'h579, co:1'b0};
      vecs[7] = '{a:12'hABC, b:12'h111, ci:1'b1, sum:12'hBCE, co:1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_c_in = 1'b0;

      // Reset state
      #22;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_sum",       {20'd0, sum},       32'd0);
      chk("rst_c_out",     {31'd0, c_out},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table-driven single operations
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].ci, lat, rs, rc, hold_ok);
         chk($sformatf("vec%0d_latency", i), lat, 32'd4);
         chk($sformatf("vec%0d_sum", i), {20'd0, rs}, {20'd0, vecs[i].sum});
         chk($sformatf("vec%0d_c_out", i), {31'd0, rc}, {31'd0, vecs[i].co});
         chk($sformatf("vec%0d_busy_not_ready", i), {31'd0, hold_ok}, 32'd1);
         chk($sformatf("vec%0d_idle_after", i), {31'd0, in_ready}, 32'd1);
      end

      // Backpressure in DONE with new operands offered
      n0 = n_acc;
      a = 12'h7FF; b = 12'h001; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      a = 12'h123; b = 12'h456; c_in = 1'b1;
      k = 0;
      while (!out_valid && k < 50) begin
         tick();
         k++;
      end
      chk("bp_reached_done", {31'd0, out_valid}, 32'd1);
      s0 = sum; c0 = c_out; stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (sum !== s0 || c_out !== c0 || !out_valid || in_ready) stable = 1'b0;
      end
      chk("bp_stable", {31'd0, stable}, 32'd1);
      chk("bp_sum", {20'd0, sum}, 32'h800);
      chk("bp_c_out", {31'd0, c_out}, 32'd0);
      chk("bp_single_accept", n_acc - n0, 32'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_idle_after", {31'd0, in_ready}, 32'd1);

      // Reset asserted mid-RUN aborts the operation
      a = 12'hABC; b = 12'h123; c_in = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy",      {31'd0, busy},      32'd0);
      chk("abort_sum",       {20'd0, sum},       32'd0);
      chk("abort_c_out",     {31'd0, c_out},     32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid || !in_ready) stable = 1'b0;
      end
      chk("abort_no_result", {31'd0, stable}, 32'd1);
      run_op(12'h001, 12'h002, 1'b0, lat, rs, rc, hold_ok);
      chk("abort_next_sum", {20'd0, rs}, 32'h003);
      chk("abort_next_c_out", {31'd0, rc}, 32'd0);

      // Back-to-back operations with in_valid and out_ready held high
      acc1 = -1; acc2 = -1; rise1 = -1;
      a = 12'h0F0; b = 12'h00F; c_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      for (int kk = 0; kk < 40 && acc2 < 0; kk++) begin
         @(negedge clk);
         if (in_valid && in_ready) begin
            if (acc1 < 0) acc1 = kk;
            else          acc2 = kk;
         end
         if (out_valid && rise1 < 0) rise1 = kk;
         tick();
         if (acc1 >= 0) begin
            a = 12'hFFF; b = 12'h800; c_in = 1'b0;
         end
      end
      in_valid = 1'b0;
      k = 0;
      while (exp_q.size() != 0 && k < 30) begin
         tick();
         k++;
      end
      out_ready = 1'b0;
      chk("b2b_accept_period", acc2 - acc1, 32'd6);
      chk("b2b_accept_after_rise", acc2 - (rise1 - 1), 32'd2);
      chk("b2b_results_drained", exp_q.size(), 32'd0);

      // Single-beat build
      s_a = 3'd7; s_b = 3'd7; s_c_in = 1'b1; s_in_valid = 1'b1;
      chk("small_in_ready", {31'd0, s_in_ready}, 32'd1);
      tick();
      s_in_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!s_out_valid && lat < 20);
      chk("small_latency", lat, 32'd1);
      chk("small_sum", {29'd0, s_sum}, 32'd7);
      chk("small_c_out", {31'd0, s_c_out}, 32'd1);
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
      chk("small_idle_after", {31'd0, s_in_ready}, 32'd1);

      // Random operations with random result backpressure
      n0 = n_acc;
      cyc = 0;
      while ((n_acc < n0 + 1000 || exp_q.size() != 0) && cyc < 20000) begin
         in_valid  = (n_acc < n0 + 1000);
         a         = 12'($urandom);
         b         = 12'($urandom);
         c_in      = 1'($urandom);
         out_ready = 1'($urandom);
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("random_completed", {31'd0, (cyc < 20000)}, 32'd1);
      chk("random_accept_count", n_acc - n0, 32'd1000);
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
